// File: rtl/iro_pkg.sv
// ---------------------------------------------------------------------------
// iro_pkg
// Shared definitions for the ring-oscillator frequency counter.
//   iro_state_e        : measurement FSM states (IDLE, ARM, GATE, DONE)
//   GATE_MIN_LOG2_DEF  : default log2 of the shortest gate window
//   BYTE_LO/MID/HI     : readout selectors for result bytes 0..2
//   STATUS_BYTE        : readout selector for the status byte
//   gate_cycles()      : gate window length in clk cycles for a gate_sel code
// ---------------------------------------------------------------------------
package iro_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2,
        DONE = 2'd3
    } iro_state_e;

    localparam int GATE_MIN_LOG2_DEF = 8;

    localparam logic [1:0] BYTE_LO     = 2'd0;
    localparam logic [1:0] BYTE_MID    = 2'd1;
    localparam logic [1:0] BYTE_HI     = 2'd2;
    localparam logic [1:0] STATUS_BYTE = 2'd3;

    // Gate window length: 2^(min_log2 + sel) clk cycles.
    function automatic logic [31:0] gate_cycles(input int unsigned min_log2,
                                                input logic [2:0]  sel);
        return 32'd1 << (min_log2 + 32'(sel));
    endfunction

endpackage

// File: rtl/iro_freq_counter_if.sv
// ---------------------------------------------------------------------------
// iro_freq_counter_if
// Control and readout bundle of the frequency counter.
//   ena       : block enable (low forces IDLE)
//   start     : measurement request, rising edge detected inside the block
//   gate_sel  : gate window select, captured at start
//   byte_sel  : readout byte select
//   rd_data   : registered readout byte
//   valid     : result register holds a completed measurement
//   busy      : measurement in progress (ARM or GATE)
//   overflow  : latched count saturated
// master = the controlling side, slave = the counter.
// ---------------------------------------------------------------------------
interface iro_freq_counter_if;

    logic       ena;
    logic       start;
    logic [2:0] gate_sel;
    logic [1:0] byte_sel;
    logic [7:0] rd_data;
    logic       valid;
    logic       busy;
    logic       overflow;

    modport master (
        output ena, start, gate_sel, byte_sel,
        input  rd_data, valid, busy, overflow
    );

    modport slave (
        input  ena, start, gate_sel, byte_sel,
        output rd_data, valid, busy, overflow
    );

endinterface

// File: rtl/iro_sync.sv
// ---------------------------------------------------------------------------
// iro_sync
// Flop-chain synchroniser followed by a history flop, producing a one-cycle
// pulse for every rising edge of the synchronised input.
//   clk, rst_n : clock and asynchronous active-low reset
//   async_in   : input to be synchronised / edge-detected
//   edge_pulse : high for one cycle after each rising edge of async_in
// With STAGES = 1 it serves as a plain registered rising-edge detector.
// ---------------------------------------------------------------------------
module iro_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;
    logic              prev_q;
    logic              prev_d;

    // Shift written as a left shift so that STAGES = 1 needs no special case.
    always_comb begin
        chain_d = (chain_q << 1) | STAGES'(async_in);
        prev_d  = chain_q[STAGES-1];
    end

    // Chain and history flops sample every cycle regardless of FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign edge_pulse = chain_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/iro_freq_counter.sv
// ---------------------------------------------------------------------------
// iro_freq_counter
// Measures the frequency of one ring-oscillator phase by counting its rising
// edges over a programmable gate window of clk cycles, and latches the count
// as a result readable one byte at a time.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   osc_in   : asynchronous oscillator phase, frequency below clk/2
//   bus      : control/readout bundle (slave side), see iro_freq_counter_if
// Parameters:
//   CNT_W          : edge counter / result width (8..24)
//   GATE_MIN_LOG2  : log2 of the shortest gate window
//   SYNC_STAGES    : synchroniser depth on osc_in (>= 2)
// ---------------------------------------------------------------------------
module iro_freq_counter
    import iro_pkg::*;
#(
    parameter int CNT_W         = 20,
    parameter int GATE_MIN_LOG2 = GATE_MIN_LOG2_DEF,
    parameter int SYNC_STAGES   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               osc_in,
    iro_freq_counter_if.slave  bus
);

    // Timer must hold 2^(GATE_MIN_LOG2+7) - 1 for the longest window.
    localparam int TMR_W = GATE_MIN_LOG2 + 7;
    localparam int ARM_W = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES - 1);

    logic osc_edge;
    logic start_rise;

    iro_sync #(.STAGES(SYNC_STAGES)) u_osc_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (osc_in),
        .edge_pulse (osc_edge)
    );

    iro_sync #(.STAGES(1)) u_start_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (bus.start),
        .edge_pulse (start_rise)
    );

    iro_state_e         state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [CNT_W-1:0]   result_q, result_d;
    logic [TMR_W-1:0]   timer_q,  timer_d;
    logic [ARM_W-1:0]   arm_q,    arm_d;
    logic               valid_q,  valid_d;
    logic               busy_q,   busy_d;
    logic               ovf_q,    ovf_d;
    logic [7:0]         rd_q,     rd_d;
    logic [23:0]        result_ext;

    // Measurement FSM. ena low overrides everything and parks the block in
    // IDLE; result and valid are left alone so a finished measurement
    // survives, while an aborted one already cleared valid when it started.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        timer_d  = timer_q;
        arm_d    = arm_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;

        if (!bus.ena) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_rise) begin
                        state_d = ARM;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        valid_d = 1'b0;
                        timer_d = TMR_W'(gate_cycles(GATE_MIN_LOG2, bus.gate_sel) - 32'd1);
                        arm_d   = ARM_LAST;
                    end
                end
                // Lets edges already inside the synchroniser drain uncounted.
                ARM: begin
                    if (arm_q == '0) begin
                        state_d = GATE;
                    end else begin
                        arm_d = arm_q - 1'b1;
                    end
                end
                // The edge in the timer==0 cycle is still counted, so the
                // window is exactly timer-load + 1 cycles long.
                GATE: begin
                    if (osc_edge) begin
                        if (&cnt_q) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    timer_d = timer_q - 1'b1;
                    if (timer_q == '0) begin
                        state_d  = DONE;
                        result_d = cnt_d;
                        valid_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == ARM) || (state_d == GATE);
    end

    // Registered readout mux; result bytes above CNT_W read as zero.
    always_comb begin
        result_ext               = '0;
        result_ext[CNT_W-1:0]    = result_q;
        rd_d                     = '0;
        case (bus.byte_sel)
            BYTE_LO:     rd_d = result_ext[7:0];
            BYTE_MID:    rd_d = result_ext[15:8];
            BYTE_HI:     rd_d = result_ext[23:16];
            STATUS_BYTE: rd_d = {ovf_q, busy_q, valid_q, state_q, 3'b000};
            default:     rd_d = '0;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            timer_q  <= '0;
            arm_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            timer_q  <= timer_d;
            arm_q    <= arm_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            rd_q     <= rd_d;
        end
    end

    assign bus.rd_data  = rd_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_iro_freq_counter.sv
// ---------------------------------------------------------------------------
// tb_iro_freq_counter
// Directed self-checking bench. Two counters share clk/rst_n: dut with
// CNT_W = 20 for the counting scenarios, dut_sat with CNT_W = 6 for
// saturation. osc inputs are driven on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_iro_freq_counter;

    import iro_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic osc_a = 1'b0;
    logic osc_s = 1'b0;
    logic osc_man = 1'b0;
    int   osc_period = 0;
    int   osc_phase  = 0;

    int checks = 0;
    int errors = 0;

    iro_freq_counter_if bus ();
    iro_freq_counter_if bus_s ();

    iro_freq_counter #(.CNT_W(20), .GATE_MIN_LOG2(8), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc_a),
        .bus    (bus)
    );

    iro_freq_counter #(.CNT_W(6), .GATE_MIN_LOG2(8), .SYNC_STAGES(2)) dut_sat (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc_s),
        .bus    (bus_s)
    );

    always #5 clk = ~clk;

    // osc_period = 0 selects manual control through osc_man.
    always @(negedge clk) begin
        osc_s = ~osc_s;
        if (osc_period == 0) begin
            osc_a = osc_man;
        end else begin
            osc_phase = (osc_phase + 1) % osc_period;
            osc_a     = (osc_phase < osc_period / 2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic readByte(input logic [1:0] sel, output logic [7:0] val);
        bus.byte_sel = sel;
        tick();
        val = bus.rd_data;
    endtask

    // Starts a measurement on dut and runs until busy drops (or limit).
    // restart_at: sample index where start is re-pulsed and gate_sel changed.
    // man_at: sample index where the manual osc is raised.
    task automatic applyStimulus(input logic [2:0] gsel, input int period,
                                 input int limit, input int restart_at,
                                 input int man_at, output int busy_len);
        int n;
        osc_period   = period;
        osc_man      = 1'b0;
        bus.gate_sel = gsel;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.busy && n < 10) begin
            tick();
            n++;
        end
        checkOutput("busy_rise", 32'(bus.busy), 32'd1);
        checkOutput("valid_clr", 32'(bus.valid), 32'd0);
        busy_len = 0;
        while (bus.busy && busy_len < limit) begin
            if (busy_len == restart_at) begin
                bus.start    = 1'b1;
                bus.gate_sel = 3'd7;
            end else if (busy_len == restart_at + 1) begin
                bus.start = 1'b0;
            end
            if (busy_len == man_at) osc_man = 1'b1;
            tick();
            busy_len++;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int         len;
        int         n;

        bus.ena = 1'b1;   bus.start = 1'b0;   bus.gate_sel = 3'd0;   bus.byte_sel = 2'd0;
        bus_s.ena = 1'b1; bus_s.start = 1'b0; bus_s.gate_sel = 3'd0; bus_s.byte_sel = 2'd0;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        checkOutput("rst_rd_data", 32'(bus.rd_data), 32'h00);
        checkOutput("rst_valid", 32'(bus.valid), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
        readByte(STATUS_BYTE, b);
        checkOutput("rst_status", 32'(b), 32'h00);

        // Saturation: CNT_W = 6, edge every 2 cycles, 256-cycle window -> 128 edges
        bus_s.start = 1'b1;
        tick();
        bus_s.start = 1'b0;
        n = 0;
        while (!bus_s.valid && n < 400) begin
            tick();
            n++;
        end
        checkOutput("sat_valid", 32'(bus_s.valid), 32'd1);
        checkOutput("sat_overflow", 32'(bus_s.overflow), 32'd1);
        bus_s.byte_sel = BYTE_LO;
        tick();
        checkOutput("sat_byte0", 32'(bus_s.rd_data), 32'h3F);
        bus_s.byte_sel = STATUS_BYTE;
        tick();
        // overflow=1 busy=0 valid=1 state=DONE(11) 000 -> 1011_1000
        checkOutput("sat_status", 32'(bus_s.rd_data), 32'hB8);

        // Longest gate: 32768 cycles, period 8 -> 4096
        applyStimulus(3'd7, 8, 40000, -1, -1, len);
        checkOutput("long_busy_len", 32'(len), 32'd32770);
        checkOutput("long_valid", 32'(bus.valid), 32'd1);
        readByte(BYTE_LO, b);
        checkOutput("long_byte0", 32'(b), 32'h00);
        readByte(BYTE_MID, b);
        checkOutput("long_byte1", 32'(b), 32'h10);
        readByte(BYTE_HI, b);
        checkOutput("long_byte2", 32'(b), 32'h00);

        // Boundary: edge in the final GATE cycle is counted
        applyStimulus(3'd0, 0, 400, -1, 255, len);
        checkOutput("edge_last_len", 32'(len), 32'd258);
        readByte(BYTE_LO, b);
        checkOutput("edge_last_count", 32'(b), 32'h01);

        // Boundary: edge in the first cycle after the window is not counted
        applyStimulus(3'd0, 0, 400, -1, 256, len);
        readByte(BYTE_LO, b);
        checkOutput("edge_after_count", 32'(b), 32'h00);

        // Basic count: period 4, 256-cycle window -> 64
        applyStimulus(3'd0, 4, 400, -1, -1, len);
        checkOutput("basic_busy_len", 32'(len), 32'd258);
        checkOutput("basic_valid", 32'(bus.valid), 32'd1);
        checkOutput("basic_overflow", 32'(bus.overflow), 32'd0);
        readByte(BYTE_LO, b);
        checkOutput("basic_byte0", 32'(b), 32'h40);
        readByte(BYTE_MID, b);
        checkOutput("basic_byte1", 32'(b), 32'h00);
        readByte(BYTE_HI, b);
        checkOutput("basic_byte2", 32'(b), 32'h00);

        // start and gate_sel changes during GATE are ignored
        applyStimulus(3'd0, 4, 400, 100, -1, len);
        checkOutput("restart_busy_len", 32'(len), 32'd258);
        readByte(BYTE_LO, b);
        checkOutput("restart_byte0", 32'(b), 32'h40);

        // ena low in DONE keeps result and valid
        bus.ena = 1'b0;
        tick();
        checkOutput("ena_done_valid", 32'(bus.valid), 32'd1);
        readByte(STATUS_BYTE, b);
        checkOutput("ena_done_status", 32'(b), 32'h20);
        bus.ena = 1'b1;
        tick();

        // Abort mid-GATE
        applyStimulus(3'd0, 4, 50, -1, -1, len);
        bus.ena = 1'b0;
        tick();
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_valid", 32'(bus.valid), 32'd0);
        readByte(STATUS_BYTE, b);
        checkOutput("abort_status", 32'(b), 32'h00);
        readByte(BYTE_LO, b);
        checkOutput("abort_old_result", 32'(b), 32'h40);
        bus.ena = 1'b1;
        tick();

        // Asynchronous reset mid-GATE
        applyStimulus(3'd0, 4, 100, -1, -1, len);
        checkOutput("pre_rst_rd_data", 32'(bus.rd_data), 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("amid_rd_data", 32'(bus.rd_data), 32'h00);
        checkOutput("amid_valid", 32'(bus.valid), 32'd0);
        checkOutput("amid_busy", 32'(bus.busy), 32'd0);
        checkOutput("amid_overflow", 32'(bus.overflow), 32'd0);
        checkOutput("amid_sat_valid", 32'(bus_s.valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // Fresh measurement after reset
        applyStimulus(3'd0, 4, 400, -1, -1, len);
        checkOutput("post_rst_busy_len", 32'(len), 32'd258);
        readByte(BYTE_LO, b);
        checkOutput("post_rst_byte0", 32'(b), 32'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
